// File: rtl/vga_scanout.sv
`default_nettype none
// ==========================================================================
// vga_scanout: 160x120x3 framebuffer, 640x480@60 VGA scan-out, 4x4 pixels
// Revision 1.0
// ==========================================================================
module vga_scanout #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [2:0] iColour,
    input  logic       iPlot,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic       oHS,
    output logic       oVS,
    output logic       oBlank_n,
    output logic       oSync_n,
    output logic       oVGA_CLK,
    output logic       oFrameDone
);

    localparam int DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [9:0]  H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]  V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [7:0]  X_LIM      = 8'(X_SCREEN_PIXELS);
    localparam logic [6:0]  Y_LIM      = 7'(Y_SCREEN_PIXELS);
    localparam logic [14:0] X_STRIDE   = 15'(X_SCREEN_PIXELS);

    logic [2:0] mem [0:DEPTH-1];

    logic        pix_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [14:0] wr_addr;
    logic [14:0] rd_addr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic        wr_en;
    logic        hs_raw;
    logic        vs_raw;
    logic        vis_raw;
    logic [2:0]  s1_data;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_vis;

    // A plot coincident with reset is dropped along with out-of-range coordinates
    assign wr_en   = Resetn && iPlot && (iX < X_LIM) && (iY < Y_LIM);
    assign wr_addr = 15'(iY) * X_STRIDE + 15'(iX);
    assign wr_idx  = wr_addr[AW-1:0];

    // Each framebuffer cell covers a 4x4 block of screen pixels
    assign rd_addr = 15'(v_cnt[9:2]) * X_STRIDE + 15'(h_cnt[9:2]);
    assign rd_idx  = rd_addr[AW-1:0];

    assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    assign vis_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    assign oSync_n  = 1'b0;
    assign oVGA_CLK = pix_en;

    // Memory is deliberately not reset; clearing the screen belongs to the plotter
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_idx] <= iColour;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pix_en     <= 1'b0;
            h_cnt      <= 10'd0;
            v_cnt      <= 10'd0;
            oFrameDone <= 1'b0;
        end else begin
            pix_en     <= ~pix_en;
            oFrameDone <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= 10'd0;
                    v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    // Two-stage pipeline keeps colour, syncs and blank mutually aligned
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            s1_data  <= 3'd0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_vis   <= 1'b0;
            oR       <= 8'h00;
            oG       <= 8'h00;
            oB       <= 8'h00;
            oHS      <= 1'b1;
            oVS      <= 1'b1;
            oBlank_n <= 1'b0;
        end else if (pix_en) begin
            s1_data  <= mem[rd_idx];
            s1_hs    <= hs_raw;
            s1_vs    <= vs_raw;
            s1_vis   <= vis_raw;
            oHS      <= s1_hs;
            oVS      <= s1_vs;
            oBlank_n <= s1_vis;
            oR       <= (s1_vis && s1_data[2]) ? 8'hFF : 8'h00;
            oG       <= (s1_vis && s1_data[1]) ? 8'hFF : 8'h00;
            oB       <= (s1_vis && s1_data[0]) ? 8'hFF : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ==========================================================================
// tb_vga_scanout: scoreboard bench on a reduced 16x12 / 80x55 raster
// Revision 1.0
// ==========================================================================
module tb_vga_scanout;

    localparam int H_TOT     = 80;      // 64 + 4 + 8 + 4
    localparam int V_TOT     = 55;      // 48 + 2 + 2 + 3
    localparam int FRAME_CLK = 8800;    // 80 * 55 ticks * 2 Clocks
    localparam int FD_REL    = 7680;    // edge leaving (79,47): 2*(47*80+79)+2
    localparam int F1        = 4400;    // first tick index of frame 1

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] iX = 8'd0;
    logic [6:0] iY = 7'd0;
    logic [2:0] iColour = 3'd0;
    logic       iPlot = 1'b0;
    logic [7:0] oR, oG, oB;
    logic       oHS, oVS, oBlank_n, oSync_n, oVGA_CLK, oFrameDone;

    vga_scanout #(
        .X_SCREEN_PIXELS(16), .Y_SCREEN_PIXELS(12),
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .iX(iX), .iY(iY), .iColour(iColour), .iPlot(iPlot),
        .oR(oR), .oG(oG), .oB(oB), .oHS(oHS), .oVS(oVS), .oBlank_n(oBlank_n),
        .oSync_n(oSync_n), .oVGA_CLK(oVGA_CLK), .oFrameDone(oFrameDone)
    );

    always #10 Clock = ~Clock;

    typedef struct {
        int         p;
        int         h;
        int         v;
        logic [7:0] r, g, b;
        logic       hs, vs, bl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rel    = 0;

    // Clock edges since reset release
    always @(posedge Clock) begin
        if (!Resetn) rel <= 0;
        else         rel <= rel + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, {2'b0, oR, oG, oB, oHS, oVS, oBlank_n, oSync_n, oVGA_CLK, oFrameDone},
                    {2'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic expect_px(input int base, input int h, input int v, input logic [2:0] c,
                             input logic hs, input logic vs, input logic bl);
        exp_t e;
        e.p  = base + v * H_TOT + h;
        e.h  = h;
        e.v  = v;
        e.r  = c[2] ? 8'hFF : 8'h00;
        e.g  = c[1] ? 8'hFF : 8'h00;
        e.b  = c[0] ? 8'hFF : 8'h00;
        e.hs = hs;
        e.vs = vs;
        e.bl = bl;
        sb.push_back(e);
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        iX = x; iY = y; iColour = c; iPlot = 1'b1;
        @(posedge Clock); #1;
        iPlot = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
        while (sb.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout pix(%0d,%0d): got no sample want one", sb[0].h, sb[0].v);
            void'(sb.pop_front());
        end
    endtask

    // Monitor: the output at edge rel = 2p+4 shows counter position p
    exp_t mon_e;
    int   mon_p;
    logic mon_fd;
    always @(negedge Clock) begin
        if (Resetn) begin
            mon_fd = (rel > 0) && ((rel % FRAME_CLK) == FD_REL);
            if (mon_fd || oFrameDone) begin
                n_cmp++;
                if (oFrameDone !== mon_fd) begin
                    n_fail++;
                    $display("FAIL frame_done rel=%0d: got %b want %b", rel, oFrameDone, mon_fd);
                end
            end
            if (rel >= 4 && rel[0] == 1'b0) begin
                mon_p = rel / 2 - 2;
                while (sb.size() > 0 && sb[0].p < mon_p) begin
                    n_cmp++; n_fail++;
                    $display("FAIL missed pix(%0d,%0d): got none want sample", sb[0].h, sb[0].v);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].p == mon_p) begin
                    mon_e = sb.pop_front();
                    n_cmp++;
                    if ({oR, oG, oB, oHS, oVS, oBlank_n, oSync_n} !==
                        {mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.bl, 1'b0}) begin
                        n_fail++;
                        $display("FAIL pix(%0d,%0d): got R=%h G=%h B=%h HS=%b VS=%b BL=%b SY=%b want R=%h G=%h B=%h HS=%b VS=%b BL=%b SY=0",
                                 mon_e.h, mon_e.v, oR, oG, oB, oHS, oVS, oBlank_n, oSync_n,
                                 mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.bl);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge Clock);
        #1;
        check_reset("reset_values");
        Resetn = 1'b1;
        @(negedge Clock);
        check("vga_clk_rel0", {31'b0, oVGA_CLK}, 32'd0);
        @(negedge Clock);
        check("vga_clk_rel1", {31'b0, oVGA_CLK}, 32'd1);
        @(negedge Clock);
        check("vga_clk_rel2", {31'b0, oVGA_CLK}, 32'd0);
        @(posedge Clock); #1;

        for (int y = 0; y < 12; y++)
            for (int x = 0; x < 16; x++)
                plot(8'(x), 7'(y), 3'b000);
        plot(8'd0, 7'd0, 3'b100);
        plot(8'd15, 7'd11, 3'b111);
        plot(8'd16, 7'd5, 3'b111);
        plot(8'd3, 7'd12, 3'b111);

        n = 0;
        while (!oFrameDone && n < 10000) begin
            @(posedge Clock); #1;
            n++;
        end
        check("frame_done_seen", {31'b0, oFrameDone}, 32'd1);
        // box burst during vertical blanking of frame 0
        for (int y = 4; y < 8; y++)
            for (int x = 4; x < 8; x++)
                plot(8'(x), 7'(y), 3'b010);

        expect_px(F1, 0, 0, 3'b100, 1, 1, 1);
        expect_px(F1, 4, 0, 3'b000, 1, 1, 1);
        expect_px(F1, 63, 0, 3'b000, 1, 1, 1);
        expect_px(F1, 3, 3, 3'b100, 1, 1, 1);
        expect_px(F1, 0, 4, 3'b000, 1, 1, 1);
        expect_px(F1, 67, 10, 3'b000, 1, 1, 0);
        expect_px(F1, 68, 10, 3'b000, 0, 1, 0);
        expect_px(F1, 75, 10, 3'b000, 0, 1, 0);
        expect_px(F1, 76, 10, 3'b000, 1, 1, 0);
        expect_px(F1, 16, 16, 3'b010, 1, 1, 1);
        expect_px(F1, 32, 16, 3'b000, 1, 1, 1);
        expect_px(F1, 24, 20, 3'b010, 1, 1, 1);
        expect_px(F1, 0, 24, 3'b000, 1, 1, 1);
        expect_px(F1, 3, 24, 3'b000, 1, 1, 1);
        expect_px(F1, 31, 31, 3'b010, 1, 1, 1);
        expect_px(F1, 16, 32, 3'b000, 1, 1, 1);
        expect_px(F1, 60, 44, 3'b111, 1, 1, 1);
        expect_px(F1, 59, 47, 3'b000, 1, 1, 1);
        expect_px(F1, 63, 47, 3'b111, 1, 1, 1);
        expect_px(F1, 64, 47, 3'b000, 1, 1, 0);
        expect_px(F1, 79, 49, 3'b000, 1, 1, 0);
        expect_px(F1, 0, 50, 3'b000, 1, 0, 0);
        expect_px(F1, 75, 51, 3'b000, 0, 0, 0);
        expect_px(F1, 0, 52, 3'b000, 1, 1, 0);
        drain(20000);

        // mid-frame reset at frame 2, line 20, with a coincident write that must drop
        n = 0;
        while (rel < 20810 && n < 20000) begin
            @(posedge Clock); #1;
            n++;
        end
        Resetn = 1'b0;
        iX = 8'd1; iY = 7'd1; iColour = 3'b001; iPlot = 1'b1;
        @(posedge Clock); #1;
        iPlot = 1'b0;
        check_reset("midframe_reset_values");
        Resetn = 1'b1;

        expect_px(0, 0, 0, 3'b100, 1, 1, 1);
        expect_px(0, 5, 5, 3'b000, 1, 1, 1);
        expect_px(0, 16, 16, 3'b010, 1, 1, 1);
        expect_px(0, 60, 44, 3'b111, 1, 1, 1);
        expect_px(0, 79, 49, 3'b000, 1, 1, 0);
        expect_px(0, 0, 50, 3'b000, 1, 0, 0);
        drain(12000);
        repeat (4) @(posedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
